spi_controller: RTL and testbench
=================================

// Module: spi_controller
// PURPOSE
//  SPI controller (bus initiator, mode 0, MSB first) in the sys_clk domain. Drives spi_clk/cs/mosi to
//  the SPI peripheral. Each frame sends an 8-bit command on MOSI and captures an 18-bit response on MISO.
//  Sits between system logic (start/done handshake) and the off-block SPI pins.
// PARAMETERS
//  CLK_DIV     4   spi_clk half-period in sys_clk cycles (>=1)
//  TX_BITS     8   command bits shifted out on MOSI
//  RX_BITS     18  frame length in spi_clk cycles; MISO bits captured (>=TX_BITS)
//  CS_SETUP    2   sys_clk cycles from cs fall to first spi_clk rise
//  CS_HOLD     2   sys_clk cycles from last spi_clk fall to cs rise
//  CS_GAP      4   min sys_clk cycles cs stays high between frames
// PORTS
//  sys_clk   in   1        system clock
//  rst       in   1        reset, asynchronous, active-high
//  start     in   1        request frame; accepted only when busy==0
//  tx_data   in   TX_BITS  command, captured on accepted start
//  busy      out  1        frame in progress (incl. GAP)
//  done      out  1        1-cycle pulse, rx_data valid
//  rx_data   out  RX_BITS  last captured response, held until next done
//  spi_clk   out  1        serial clock, idles low
//  cs        out  1        chip select, active-low, idles high
//  mosi      out  1        serial data out
//  miso      in   1        serial data in (source-synchronous to spi_clk, no synchroniser)
// BEHAVIOUR
//  Reset: busy=0, done=0, rx_data=0, spi_clk=0, cs=1, mosi=0, FSM=IDLE; all outputs registered.
//  FSM IDLE->SETUP->XFER->HOLD->GAP->IDLE.
//  IDLE: start=1 at edge N -> tx_data latched, cs=0, busy=1, mosi=tx_data[TX_BITS-1] at N+1; enter SETUP.
//  SETUP: CS_SETUP cycles, spi_clk low; then XFER.
//  XFER: RX_BITS spi_clk periods, each CLK_DIV cycles high then CLK_DIV cycles low.
//   - Rising edge (register edge driving spi_clk 0->1): sample miso into rx shifter (shift left, LSB in).
//   - Falling edge (spi_clk 1->0): mosi <= next command bit; after TX_BITS bits sent, mosi=0.
//   - Bit counter 0..RX_BITS-1, terminal on fall after bit RX_BITS-1 -> HOLD (spi_clk stays 0).
//  HOLD: CS_HOLD cycles, cs=0, mosi=0; then cs=1, rx_data<=shifter, done=1 for that one cycle -> GAP.
//  GAP: CS_GAP cycles cs=1; busy drops in the cycle after GAP ends (IDLE).
//  Frame length = 1 + CS_SETUP + 2*CLK_DIV*RX_BITS + CS_HOLD sys_clk cycles from start to done.
//  Boundaries: start while busy ignored (no queueing); start held high -> back-to-back frames
//   separated by CS_GAP; tx_data changes mid-frame ignored; rst mid-frame -> immediate idle values,
//   partial rx discarded, rx_data=0; CLK_DIV=1 -> spi_clk = sys_clk/2.
// CONFIGURATION
//  SPI_CTRL_LOOPBACK_EN defined: extra input lpbk (1 bit, after miso); lpbk=1 -> rx shifter samples
//   internal mosi instead of miso (rx_data = {tx_data, (RX_BITS-TX_BITS) zeros}); pins unchanged.
//  Undefined: no lpbk port; always samples miso.
// STRUCTURE
//  Package spi_pkg: ctrl_state_t enum (IDLE,SETUP,XFER,HOLD,GAP), SPI_CMD_BITS=8, SPI_RSP_BITS=18
//   (shared with the peripheral side).
//  Sub-module spi_clk_gen: CLK_DIV counter, emits rise/fall strobes and spi_clk; FSM gates it by enable.
// TESTING
//  Peripheral model returns 18'h2_5A3C, tx_data=8'hA5, CLK_DIV=4 -> model sees A5 on MOSI, rx_data=18'h25A3C, done once.
//  Start at cycle N -> cs low N+1, done at N+1+2+144+2=N+149, busy low at N+154.
//  Start pulsed during XFER with tx_data=8'h3C -> ignored; MOSI still A5, one done only.
//  start held high 3 frames -> 3 done pulses, cs high >=4 cycles between frames, 18 spi_clk rises each.
//  rst asserted at bit 9 -> cs=1, spi_clk=0, busy=0, rx_data=0 same cycle; next frame completes normally.
//  SPI_CTRL_LOOPBACK_EN, lpbk=1, tx_data=8'hC3, miso tied 1 -> rx_data=18'h30C00.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared SPI definitions: controller state encoding and the command/response
// widths agreed with the peripheral side.
package spi_pkg;

   localparam int SPI_CMD_BITS = 8;
   localparam int SPI_RSP_BITS = 18;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      XFER,
      HOLD,
      GAP
   } ctrl_state_t;

endpackage

// File: rtl/spi_clk_gen.sv
// SPI serial clock divider: spi_clk toggles every CLK_DIV sys_clk cycles while enabled,
// with one-cycle strobes flagging the edges on which spi_clk rises and falls.
module spi_clk_gen #(
   parameter int CLK_DIV = 4
) (
   input  logic sys_clk,
   input  logic rst,
   input  logic i_enable,
   output logic o_spiClk,
   output logic o_rise,
   output logic o_fall
);

   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   logic [DIV_W-1:0] r_divCnt;
   logic             r_spiClk;
   logic             w_tick;

   assign w_tick   = i_enable && (r_divCnt == DIV_LAST);
   assign o_rise   = w_tick && !r_spiClk;
   assign o_fall   = w_tick && r_spiClk;
   assign o_spiClk = r_spiClk;

   // While disabled the divider is preloaded so the first enabled cycle produces a rise
   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         r_divCnt <= DIV_LAST;
         r_spiClk <= 1'b0;
      end else if (!i_enable) begin
         r_divCnt <= DIV_LAST;
         r_spiClk <= 1'b0;
      end else if (w_tick) begin
         r_divCnt <= '0;
         r_spiClk <= ~r_spiClk;
      end else begin
         r_divCnt <= r_divCnt + 1'b1;
      end
   end

endmodule

// File: rtl/spi_controller.sv
// SPI bus initiator (mode 0, MSB first): sends a command, captures a response per frame.
// Optional SPI_CTRL_LOOPBACK_EN adds an lpbk input that samples internal mosi instead of miso.
module spi_controller
   import spi_pkg::*;
#(
   parameter int CLK_DIV  = 4,
   parameter int TX_BITS  = SPI_CMD_BITS,
   parameter int RX_BITS  = SPI_RSP_BITS,
   parameter int CS_SETUP = 2,
   parameter int CS_HOLD  = 2,
   parameter int CS_GAP   = 4
) (
   input  logic               sys_clk,
   input  logic               rst,
   input  logic               start,
   input  logic [TX_BITS-1:0] tx_data,
   output logic               busy,
   output logic               done,
   output logic [RX_BITS-1:0] rx_data,
   output logic               spi_clk,
   output logic               cs,
   output logic               mosi,
   input  logic               miso
`ifdef SPI_CTRL_LOOPBACK_EN
   ,
   input  logic               lpbk
`endif
);

   // HOLD also absorbs the final low half-period, so frames span whole spi_clk periods
   localparam int HOLD_CYC = CLK_DIV + CS_HOLD;
   localparam int CNT_MAX  = (HOLD_CYC > CS_GAP + 1)
                           ? ((HOLD_CYC > CS_SETUP) ? HOLD_CYC : CS_SETUP)
                           : ((CS_GAP + 1 > CS_SETUP) ? CS_GAP + 1 : CS_SETUP);
   localparam int CNT_W    = $clog2(CNT_MAX + 1);
   localparam int BIT_W    = $clog2(RX_BITS);

   ctrl_state_t          r_state;
   logic [CNT_W-1:0]     r_cnt;
   logic [BIT_W-1:0]     r_bitCnt;
   logic [TX_BITS-1:0]   r_txShift;
   logic [RX_BITS-1:0]   r_rxShift;
   logic [RX_BITS-1:0]   r_rxData;
   logic                 r_cs;
   logic                 r_mosi;
   logic                 r_busy;
   logic                 r_done;

   logic                 w_clkEn;
   logic                 w_rise;
   logic                 w_fall;
   logic                 w_sampleBit;

   assign w_clkEn = (r_state == XFER) ||
                    ((r_state == SETUP) && (r_cnt == CNT_W'(CS_SETUP - 1)));

`ifdef SPI_CTRL_LOOPBACK_EN
   assign w_sampleBit = lpbk ? r_mosi : miso;
`else
   assign w_sampleBit = miso;
`endif

   spi_clk_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_clkGen (
      .sys_clk  (sys_clk),
      .rst      (rst),
      .i_enable (w_clkEn),
      .o_spiClk (spi_clk),
      .o_rise   (w_rise),
      .o_fall   (w_fall)
   );

   // Frame sequencer: r_txShift holds the bits still to be driven after the current mosi
   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         r_state   <= IDLE;
         r_cnt     <= '0;
         r_bitCnt  <= '0;
         r_txShift <= '0;
         r_rxShift <= '0;
         r_rxData  <= '0;
         r_cs      <= 1'b1;
         r_mosi    <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (w_rise) begin
            r_rxShift <= {r_rxShift[RX_BITS-2:0], w_sampleBit};
         end
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_txShift <= {tx_data[TX_BITS-2:0], 1'b0};
                  r_mosi    <= tx_data[TX_BITS-1];
                  r_rxShift <= '0;
                  r_cs      <= 1'b0;
                  r_busy    <= 1'b1;
                  r_cnt     <= '0;
                  r_bitCnt  <= '0;
                  r_state   <= SETUP;
               end
            end
            SETUP: begin
               if (r_cnt == CNT_W'(CS_SETUP - 1)) begin
                  r_cnt   <= '0;
                  r_state <= XFER;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            XFER: begin
               if (w_fall) begin
                  r_mosi    <= r_txShift[TX_BITS-1];
                  r_txShift <= {r_txShift[TX_BITS-2:0], 1'b0};
                  if (r_bitCnt == BIT_W'(RX_BITS - 1)) begin
                     r_cnt   <= '0;
                     r_state <= HOLD;
                  end else begin
                     r_bitCnt <= r_bitCnt + 1'b1;
                  end
               end
            end
            HOLD: begin
               r_mosi <= 1'b0;
               if (r_cnt == CNT_W'(HOLD_CYC - 1)) begin
                  r_cs     <= 1'b1;
                  r_done   <= 1'b1;
                  r_rxData <= r_rxShift;
                  r_cnt    <= '0;
                  r_state  <= GAP;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            GAP: begin
               if (r_cnt == CNT_W'(CS_GAP)) begin
                  r_busy  <= 1'b0;
                  r_state <= IDLE;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign busy    = r_busy;
   assign done    = r_done;
   assign rx_data = r_rxData;
   assign cs      = r_cs;
   assign mosi    = r_mosi;

endmodule

// File: tb/tb_spi_controller.sv
// Self-checking bench for spi_controller with a mode-0 peripheral model; a second
// instance runs at CLK_DIV=1. Loopback test is built when SPI_CTRL_LOOPBACK_EN is defined.
module tb_spi_controller;

   logic        sys_clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic [7:0]  txData = 8'h00;
   logic        busy, done, spiClk, cs, mosi;
   logic [17:0] rxData;
   wire         miso;

   logic        start1 = 1'b0;
   logic [7:0]  txData1 = 8'h00;
   logic        busy1, done1, spiClk1, cs1, mosi1;
   logic [17:0] rxData1;
   logic        mMiso1 = 1'b0;
   wire         miso1;

`ifdef SPI_CTRL_LOOPBACK_EN
   logic        lpbk = 1'b0;
   logic        lpbk1 = 1'b0;
`endif

   int vecCount = 0;
   int missCount = 0;
   int doneCount = 0;

   // Peripheral model: drives bit 17 at cs fall, next bit after each spi_clk fall
   logic [17:0] mResp = 18'h25A3C;
   logic        mMiso = 1'b0;
   logic        mForce = 1'b0;
   logic [7:0]  mCmd = 8'h00;
   int          mRises = 0;
   logic [17:0] mResp1 = 18'h12345;
   int          mRises1 = 0;

   assign miso  = mForce ? 1'b1 : mMiso;
   assign miso1 = mMiso1;

   always #5 sys_clk = ~sys_clk;

   spi_controller #(.CLK_DIV(4)) dut (
      .sys_clk (sys_clk),
      .rst     (rst),
      .start   (start),
      .tx_data (txData),
      .busy    (busy),
      .done    (done),
      .rx_data (rxData),
      .spi_clk (spiClk),
      .cs      (cs),
      .mosi    (mosi),
      .miso    (miso)
`ifdef SPI_CTRL_LOOPBACK_EN
      ,
      .lpbk    (lpbk)
`endif
   );

   spi_controller #(.CLK_DIV(1)) dut1 (
      .sys_clk (sys_clk),
      .rst     (rst),
      .start   (start1),
      .tx_data (txData1),
      .busy    (busy1),
      .done    (done1),
      .rx_data (rxData1),
      .spi_clk (spiClk1),
      .cs      (cs1),
      .mosi    (mosi1),
      .miso    (miso1)
`ifdef SPI_CTRL_LOOPBACK_EN
      ,
      .lpbk    (lpbk1)
`endif
   );

   always @(negedge cs) begin
      mRises = 0;
      mCmd   = 8'h00;
      mMiso  = mResp[17];
   end

   always @(posedge spiClk) begin
      if (!cs) begin
         if (mRises < 8) mCmd = {mCmd[6:0], mosi};
         mRises = mRises + 1;
      end
   end

   always @(negedge spiClk) begin
      if (!cs && mRises < 18) mMiso = mResp[17 - mRises];
   end

   always @(negedge cs1) begin
      mRises1 = 0;
      mMiso1  = mResp1[17];
   end

   always @(posedge spiClk1) begin
      if (!cs1) mRises1 = mRises1 + 1;
   end

   always @(negedge spiClk1) begin
      if (!cs1 && mRises1 < 18) mMiso1 = mResp1[17 - mRises1];
   end

   always @(negedge sys_clk) begin
      if (done === 1'b1) doneCount = doneCount + 1;
   end

   task test_reset;
      @(negedge sys_clk);
      vecCount++; if (busy !== 1'b0) begin missCount++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
      vecCount++; if (done !== 1'b0) begin missCount++; $display("[TB] FAIL reset_done: got %b want 0", done); end
      vecCount++; if (rxData !== 18'h0) begin missCount++; $display("[TB] FAIL reset_rx: got %h want 0", rxData); end
      vecCount++; if (spiClk !== 1'b0) begin missCount++; $display("[TB] FAIL reset_spiclk: got %b want 0", spiClk); end
      vecCount++; if (cs !== 1'b1) begin missCount++; $display("[TB] FAIL reset_cs: got %b want 1", cs); end
      vecCount++; if (mosi !== 1'b0) begin missCount++; $display("[TB] FAIL reset_mosi: got %b want 0", mosi); end
      rst = 1'b0;
      repeat (3) @(negedge sys_clk);
   endtask

   task test_frame_timing;
      int n;
      int doneBase;
      doneBase = doneCount;
      mResp  = 18'h25A3C;
      txData = 8'hA5;
      @(negedge sys_clk) start = 1'b1;
      @(negedge sys_clk) start = 1'b0;
      vecCount++; if (cs !== 1'b0) begin missCount++; $display("[TB] FAIL frame_cs_low: got %b want 0", cs); end
      vecCount++; if (busy !== 1'b1) begin missCount++; $display("[TB] FAIL frame_busy: got %b want 1", busy); end
      vecCount++; if (mosi !== 1'b1) begin missCount++; $display("[TB] FAIL frame_mosi_msb: got %b want 1", mosi); end
      n = 1;
      while (done !== 1'b1 && n < 400) begin @(negedge sys_clk); n++; end
      vecCount++; if (n !== 149) begin missCount++; $display("[TB] FAIL frame_done_cycle: got %0d want 149", n); end
      vecCount++; if (rxData !== 18'h25A3C) begin missCount++; $display("[TB] FAIL frame_rx: got %h want 25a3c", rxData); end
      vecCount++; if (mCmd !== 8'hA5) begin missCount++; $display("[TB] FAIL frame_cmd: got %h want a5", mCmd); end
      vecCount++; if (mRises !== 18) begin missCount++; $display("[TB] FAIL frame_rises: got %0d want 18", mRises); end
      vecCount++; if (cs !== 1'b1) begin missCount++; $display("[TB] FAIL frame_cs_high: got %b want 1", cs); end
      while (busy !== 1'b0 && n < 400) begin @(negedge sys_clk); n++; end
      vecCount++; if (n !== 154) begin missCount++; $display("[TB] FAIL frame_busy_low: got %0d want 154", n); end
      repeat (3) @(negedge sys_clk);
      vecCount++; if (doneCount - doneBase !== 1) begin missCount++; $display("[TB] FAIL frame_done_pulses: got %0d want 1", doneCount - doneBase); end
   endtask

   task test_start_ignored;
      int n;
      int doneBase;
      doneBase = doneCount;
      txData = 8'hA5;
      @(negedge sys_clk) start = 1'b1;
      @(negedge sys_clk) start = 1'b0;
      repeat (60) @(negedge sys_clk);
      txData = 8'h3C;
      start  = 1'b1;
      @(negedge sys_clk) start = 1'b0;
      n = 0;
      while (done !== 1'b1 && n < 400) begin @(negedge sys_clk); n++; end
      vecCount++; if (rxData !== 18'h25A3C) begin missCount++; $display("[TB] FAIL ignore_rx: got %h want 25a3c", rxData); end
      vecCount++; if (mCmd !== 8'hA5) begin missCount++; $display("[TB] FAIL ignore_cmd: got %h want a5", mCmd); end
      while (busy !== 1'b0 && n < 400) begin @(negedge sys_clk); n++; end
      repeat (20) @(negedge sys_clk);
      vecCount++; if (busy !== 1'b0) begin missCount++; $display("[TB] FAIL ignore_no_queue: got busy %b want 0", busy); end
      vecCount++; if (doneCount - doneBase !== 1) begin missCount++; $display("[TB] FAIL ignore_done_pulses: got %0d want 1", doneCount - doneBase); end
   endtask

   task test_back_to_back;
      int doneSeen;
      int csRun;
      int minGap;
      int rises [3];
      int n;
      doneSeen = 0;
      csRun    = 0;
      minGap   = 1000;
      txData   = 8'hA5;
      @(negedge sys_clk) start = 1'b1;
      for (int c = 0; c < 700 && doneSeen < 3; c++) begin
         @(negedge sys_clk);
         if (cs === 1'b1) begin
            csRun++;
         end else begin
            if (doneSeen > 0 && csRun > 0 && csRun < minGap) minGap = csRun;
            csRun = 0;
         end
         if (done === 1'b1) begin
            rises[doneSeen] = mRises;
            doneSeen++;
            if (doneSeen == 3) start = 1'b0;
         end
      end
      start = 1'b0;
      vecCount++; if (doneSeen !== 3) begin missCount++; $display("[TB] FAIL b2b_done_count: got %0d want 3", doneSeen); end
      for (int f = 0; f < 3; f++) begin
         vecCount++; if (rises[f] !== 18) begin missCount++; $display("[TB] FAIL b2b_rises_%0d: got %0d want 18", f, rises[f]); end
      end
      // cs rises with done and falls one cycle after busy drops: 6 cycles high
      vecCount++; if (minGap !== 6) begin missCount++; $display("[TB] FAIL b2b_cs_gap: got %0d want 6", minGap); end
      vecCount++; if (rxData !== 18'h25A3C) begin missCount++; $display("[TB] FAIL b2b_rx: got %h want 25a3c", rxData); end
      n = 0;
      while (busy !== 1'b0 && n < 400) begin @(negedge sys_clk); n++; end
      repeat (10) @(negedge sys_clk);
      vecCount++; if (busy !== 1'b0) begin missCount++; $display("[TB] FAIL b2b_idle: got busy %b want 0", busy); end
   endtask

   task test_reset_mid_frame;
      int n;
      txData = 8'hA5;
      @(negedge sys_clk) start = 1'b1;
      @(negedge sys_clk) start = 1'b0;
      n = 0;
      while (mRises < 10 && n < 300) begin @(negedge sys_clk); n++; end
      vecCount++; if (cs !== 1'b0) begin missCount++; $display("[TB] FAIL rstmid_in_frame: got cs %b want 0", cs); end
      rst = 1'b1;
      #1;
      vecCount++; if (cs !== 1'b1) begin missCount++; $display("[TB] FAIL rstmid_cs: got %b want 1", cs); end
      vecCount++; if (spiClk !== 1'b0) begin missCount++; $display("[TB] FAIL rstmid_spiclk: got %b want 0", spiClk); end
      vecCount++; if (busy !== 1'b0) begin missCount++; $display("[TB] FAIL rstmid_busy: got %b want 0", busy); end
      vecCount++; if (rxData !== 18'h0) begin missCount++; $display("[TB] FAIL rstmid_rx: got %h want 0", rxData); end
      vecCount++; if (mosi !== 1'b0) begin missCount++; $display("[TB] FAIL rstmid_mosi: got %b want 0", mosi); end
      @(negedge sys_clk) rst = 1'b0;
      repeat (2) @(negedge sys_clk);
      mResp  = 18'h3C0F1;
      txData = 8'h5A;
      @(negedge sys_clk) start = 1'b1;
      @(negedge sys_clk) start = 1'b0;
      n = 1;
      while (done !== 1'b1 && n < 400) begin @(negedge sys_clk); n++; end
      vecCount++; if (n !== 149) begin missCount++; $display("[TB] FAIL rstmid_next_done: got %0d want 149", n); end
      vecCount++; if (rxData !== 18'h3C0F1) begin missCount++; $display("[TB] FAIL rstmid_next_rx: got %h want 3c0f1", rxData); end
      vecCount++; if (mCmd !== 8'h5A) begin missCount++; $display("[TB] FAIL rstmid_next_cmd: got %h want 5a", mCmd); end
      while (busy !== 1'b0 && n < 400) begin @(negedge sys_clk); n++; end
      mResp = 18'h25A3C;
   endtask

   task test_clk_div1;
      int n;
      int hiCnt;
      txData1 = 8'h81;
      @(negedge sys_clk) start1 = 1'b1;
      @(negedge sys_clk) start1 = 1'b0;
      n = 1;
      hiCnt = 0;
      while (done1 !== 1'b1 && n < 200) begin
         if (spiClk1 === 1'b1) hiCnt++;
         @(negedge sys_clk);
         n++;
      end
      vecCount++; if (n !== 41) begin missCount++; $display("[TB] FAIL div1_done_cycle: got %0d want 41", n); end
      vecCount++; if (hiCnt !== 18) begin missCount++; $display("[TB] FAIL div1_high_cycles: got %0d want 18", hiCnt); end
      vecCount++; if (rxData1 !== 18'h12345) begin missCount++; $display("[TB] FAIL div1_rx: got %h want 12345", rxData1); end
      vecCount++; if (mRises1 !== 18) begin missCount++; $display("[TB] FAIL div1_rises: got %0d want 18", mRises1); end
      while (busy1 !== 1'b0 && n < 200) begin @(negedge sys_clk); n++; end
   endtask

`ifdef SPI_CTRL_LOOPBACK_EN
   task test_loopback;
      int n;
      lpbk   = 1'b1;
      mForce = 1'b1;
      txData = 8'hC3;
      @(negedge sys_clk) start = 1'b1;
      @(negedge sys_clk) start = 1'b0;
      n = 0;
      while (done !== 1'b1 && n < 400) begin @(negedge sys_clk); n++; end
      vecCount++; if (rxData !== 18'h30C00) begin missCount++; $display("[TB] FAIL lpbk_rx: got %h want 30c00", rxData); end
      vecCount++; if (mCmd !== 8'hC3) begin missCount++; $display("[TB] FAIL lpbk_pin_cmd: got %h want c3", mCmd); end
      while (busy !== 1'b0 && n < 400) begin @(negedge sys_clk); n++; end
      lpbk   = 1'b0;
      mForce = 1'b0;
   endtask
`endif

   initial begin
      #1 rst = 1'b1;
      test_reset();
      test_frame_timing();
      test_start_ignored();
      test_back_to_back();
      test_reset_mid_frame();
      test_clk_div1();
`ifdef SPI_CTRL_LOOPBACK_EN
      test_loopback();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
      $finish;
   end

endmodule
